// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : shared axis-mode record, 640x480@60 timing and mode legality check
// Rev 1.0
// ============================================================================
package vga_pkg;

  localparam int c_MODE_W = 16;

  // One axis of a video mode: active end, sync start, sync end, total
  typedef struct packed {
    logic [c_MODE_W-1:0] width;
    logic [c_MODE_W-1:0] porch;
    logic [c_MODE_W-1:0] synch;
    logic [c_MODE_W-1:0] raw;
  } mode_t;

  localparam mode_t c_H_640 = '{width: 16'd640, porch: 16'd656, synch: 16'd752, raw: 16'd800};
  localparam mode_t c_V_480 = '{width: 16'd480, porch: 16'd490, synch: 16'd492, raw: 16'd525};

  function automatic logic mode_legal(input mode_t m);
    return (m.width < m.porch) && (m.porch < m.synch) && (m.synch <= m.raw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// vga_axis_counter : one raster axis - shadowed mode, wrapping position, decode
// Rev 1.0
// ============================================================================
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_width,
  input  logic [W-1:0] i_porch,
  input  logic [W-1:0] i_synch,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_width,
  output logic         o_last,
  output logic         o_active,
  output logic         o_sync,
  output logic         o_next_legal
);

  logic [W-1:0] pos_q,   pos_d;
  logic [W-1:0] width_q, width_d;
  logic [W-1:0] porch_q, porch_d;
  logic [W-1:0] synch_q, synch_d;
  logic [W-1:0] raw_q,   raw_d;
  logic         w_last;
  mode_t        w_next_mode;

  always_comb begin
    width_d = width_q;
    porch_d = porch_q;
    synch_d = synch_q;
    raw_d   = raw_q;
    if (i_load) begin
      width_d = i_width;
      porch_d = i_porch;
      synch_d = i_synch;
      raw_d   = i_raw;
    end

    // Legality of whatever the shadow will hold after this edge
    w_next_mode.width = c_MODE_W'(width_d);
    w_next_mode.porch = c_MODE_W'(porch_d);
    w_next_mode.synch = c_MODE_W'(synch_d);
    w_next_mode.raw   = c_MODE_W'(raw_d);
    o_next_legal      = mode_legal(w_next_mode);

    w_last = (pos_q == raw_q - W'(1));

    pos_d = pos_q;
    if (i_load) begin
      pos_d = '0;
    end else if (i_en) begin
      pos_d = w_last ? '0 : pos_q + W'(1);
    end

    o_last   = w_last;
    o_active = (pos_q < width_q);
    o_sync   = (pos_q >= porch_q) && (pos_q < synch_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q   <= '0;
      width_q <= '0;
      porch_q <= '0;
      synch_q <= '0;
      raw_q   <= '0;
    end else begin
      pos_q   <= pos_d;
      width_q <= width_d;
      porch_q <= porch_d;
      synch_q <= synch_d;
      raw_q   <= raw_d;
    end
  end

  assign o_width = width_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : raster timing, source strobes and registered RGB/sync sink.
// Define VGA_SYNC_POLARITY_EN for per-mode sync polarity inputs.   Rev 1.0
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int BITS_PER_COLOR = 4,
  parameter int HW             = 12,
  parameter int VW             = 12
) (
  input  logic                        i_pixclk,
  input  logic                        i_reset,
  input  logic [HW-1:0]               i_hm_width,
  input  logic [HW-1:0]               i_hm_porch,
  input  logic [HW-1:0]               i_hm_synch,
  input  logic [HW-1:0]               i_hm_raw,
  input  logic [VW-1:0]               i_vm_height,
  input  logic [VW-1:0]               i_vm_porch,
  input  logic [VW-1:0]               i_vm_synch,
  input  logic [VW-1:0]               i_vm_raw,
`ifdef VGA_SYNC_POLARITY_EN
  input  logic                        i_hsync_pol,
  input  logic                        i_vsync_pol,
`endif
  output logic [HW-1:0]               o_width,
  output logic [VW-1:0]               o_height,
  output logic                        o_rd,
  output logic                        o_newline,
  output logic                        o_newframe,
  input  logic [3*BITS_PER_COLOR-1:0] i_pixel,
  output logic [BITS_PER_COLOR-1:0]   o_vga_red,
  output logic [BITS_PER_COLOR-1:0]   o_vga_grn,
  output logic [BITS_PER_COLOR-1:0]   o_vga_blu,
  output logic                        o_vga_hsync,
  output logic                        o_vga_vsync,
  output logic                        o_err
);

  localparam int c_BPC = BITS_PER_COLOR;

  logic w_h_last, w_h_active, w_h_sync, w_h_legal;
  logic w_v_last, w_v_active, w_v_sync, w_v_legal;
  logic w_load, w_run, w_hpol, w_vpol;

  logic load_q,     load_d;
  logic err_q,      err_d;
  logic rd_q,       rd_d;
  logic newline_q,  newline_d;
  logic newframe_q, newframe_d;
  logic hs1_q,      hs1_d;
  logic vs1_q,      vs1_d;
  logic act2_q,     act2_d;
  logic hs2_q,      hs2_d;
  logic vs2_q,      vs2_d;
  logic hsync_q,    hsync_d;
  logic vsync_q,    vsync_d;
  logic [c_BPC-1:0] red_q, red_d;
  logic [c_BPC-1:0] grn_q, grn_d;
  logic [c_BPC-1:0] blu_q, blu_d;

  // End of frame reloads the shadow on the same edge the counters wrap
  assign w_load = load_q | (w_h_last & w_v_last);
  assign w_run  = ~load_q & ~err_q;

  vga_axis_counter #(.W(HW)) u_h_axis (
    .clk          (i_pixclk),
    .rst          (i_reset),
    .i_load       (w_load),
    .i_en         (1'b1),
    .i_width      (i_hm_width),
    .i_porch      (i_hm_porch),
    .i_synch      (i_hm_synch),
    .i_raw        (i_hm_raw),
    .o_width      (o_width),
    .o_last       (w_h_last),
    .o_active     (w_h_active),
    .o_sync       (w_h_sync),
    .o_next_legal (w_h_legal)
  );

  vga_axis_counter #(.W(VW)) u_v_axis (
    .clk          (i_pixclk),
    .rst          (i_reset),
    .i_load       (w_load),
    .i_en         (w_h_last),
    .i_width      (i_vm_height),
    .i_porch      (i_vm_porch),
    .i_synch      (i_vm_synch),
    .i_raw        (i_vm_raw),
    .o_width      (o_height),
    .o_last       (w_v_last),
    .o_active     (w_v_active),
    .o_sync       (w_v_sync),
    .o_next_legal (w_v_legal)
  );

`ifdef VGA_SYNC_POLARITY_EN
  logic hpol_q, hpol_d;
  logic vpol_q, vpol_d;

  always_comb begin
    hpol_d = w_load ? i_hsync_pol : hpol_q;
    vpol_d = w_load ? i_vsync_pol : vpol_q;
  end

  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      hpol_q <= 1'b0;
      vpol_q <= 1'b0;
    end else begin
      hpol_q <= hpol_d;
      vpol_q <= vpol_d;
    end
  end

  assign w_hpol = hpol_q;
  assign w_vpol = vpol_q;
`else
  assign w_hpol = 1'b0;
  assign w_vpol = 1'b0;
`endif

  always_comb begin
    // An illegal shadow keeps the block reloading until the inputs are fixed
    load_d     = ~(w_h_legal & w_v_legal);
    err_d      = ~(w_h_legal & w_v_legal);
    rd_d       = w_run & w_h_active & w_v_active;
    newline_d  = w_run & w_h_last;
    newframe_d = w_run & w_h_last & w_v_last;
    hs1_d      = w_run & w_h_sync;
    vs1_d      = w_run & w_v_sync;
    act2_d     = rd_q;
    hs2_d      = hs1_q;
    vs2_d      = vs1_q;
    red_d      = act2_q ? i_pixel[3*c_BPC-1 -: c_BPC] : '0;
    grn_d      = act2_q ? i_pixel[2*c_BPC-1 -: c_BPC] : '0;
    blu_d      = act2_q ? i_pixel[c_BPC-1:0]          : '0;
    hsync_d    = w_hpol ? hs2_q : ~hs2_q;
    vsync_d    = w_vpol ? vs2_q : ~vs2_q;
  end

  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      load_q     <= 1'b1;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
      newline_q  <= 1'b0;
      newframe_q <= 1'b0;
      hs1_q      <= 1'b0;
      vs1_q      <= 1'b0;
      act2_q     <= 1'b0;
      hs2_q      <= 1'b0;
      vs2_q      <= 1'b0;
      red_q      <= '0;
      grn_q      <= '0;
      blu_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
    end else begin
      load_q     <= load_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      newline_q  <= newline_d;
      newframe_q <= newframe_d;
      hs1_q      <= hs1_d;
      vs1_q      <= vs1_d;
      act2_q     <= act2_d;
      hs2_q      <= hs2_d;
      vs2_q      <= vs2_d;
      red_q      <= red_d;
      grn_q      <= grn_d;
      blu_q      <= blu_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign o_rd        = rd_q;
  assign o_newline   = newline_q;
  assign o_newframe  = newframe_q;
  assign o_vga_red   = red_q;
  assign o_vga_grn   = grn_q;
  assign o_vga_blu   = blu_q;
  assign o_vga_hsync = hsync_q;
  assign o_vga_vsync = vsync_q;
  assign o_err       = err_q;

endmodule
`default_nettype wire
